// File: rtl/demosaicing_frame_ctrl.sv
// Frame-synchronous config sequencer: holds CSR enable/pattern updates pending and commits them between frames.
// Optional DEMOSAICING_FRAME_STAT_EN exposes the frame and line counters on frame_cnt_o/line_cnt_o.
module demosaicing_frame_ctrl #(
  parameter int FRAME_LINES = 1080,
  parameter int LINE_CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_i,
  input  logic                  cfg_upd_i,
  input  logic                  tvalid_i,
  input  logic                  tready_i,
  input  logic                  tuser_i,
  input  logic                  tlast_i,
  output logic                  hold_o,
  output logic                  en_o,
  output logic [1:0]            pattern_o,
  output logic                  cfg_pending_o,
  output logic                  cfg_applied_o,
  output logic                  sof_err_o,
  output logic [31:0]           frame_cnt_o,
  output logic [LINE_CNT_W-1:0] line_cnt_o
);
  typedef enum logic [1:0] {WAIT_SOF, COMMIT, ACTIVE} state_e;

  localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(FRAME_LINES - 1);

  state_e                state_q, state_d;
  logic                  en_q, en_d, pend_en_q, pend_en_d;
  logic [1:0]            pat_q, pat_d, pend_pat_q, pend_pat_d;
  logic                  pending_q, pending_d, applied_q, applied_d;
  logic                  sof_err_q, sof_err_d;
  logic [LINE_CNT_W-1:0] line_q, line_d;
  logic                  beat;

  assign beat = tvalid_i & tready_i;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    pat_d      = pat_q;
    pend_en_d  = pend_en_q;
    pend_pat_d = pend_pat_q;
    pending_d  = pending_q;
    applied_d  = 1'b0;
    sof_err_d  = sof_err_q;
    line_d     = line_q;
    hold_o     = 1'b0;
    if (cfg_upd_i) begin
      pend_en_d  = en_i;
      pend_pat_d = pattern_i;
      pending_d  = 1'b1;
    end
    case (state_q)
      WAIT_SOF: begin
        hold_o = pending_q;
        // A fresh update loses to a same-cycle SOF so the accepted beat is never dropped;
        // it then waits pending for the end of that frame.
        if (pending_q) begin
          state_d = COMMIT;
        end else if (beat && tuser_i) begin
          state_d = ACTIVE;
          line_d  = LINE_CNT_W'(tlast_i);
        end else if (cfg_upd_i) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        hold_o    = 1'b1;
        en_d      = pend_en_q;
        pat_d     = pend_pat_q;
        applied_d = 1'b1;
        pending_d = cfg_upd_i;
        state_d   = WAIT_SOF;
      end
      ACTIVE: begin
        if (beat && tuser_i) begin
          if (line_q != '0) sof_err_d = 1'b1;
          line_d = LINE_CNT_W'(tlast_i);
        end else if (beat && tlast_i) begin
          if (line_q == LAST_LINE) begin
            state_d = WAIT_SOF;
            line_d  = '0;
          end else begin
            line_d = line_q + LINE_CNT_W'(1);
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= WAIT_SOF;
      en_q       <= 1'b0;
      pat_q      <= 2'b00;
      pend_en_q  <= 1'b0;
      pend_pat_q <= 2'b00;
      pending_q  <= 1'b0;
      applied_q  <= 1'b0;
      sof_err_q  <= 1'b0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      pat_q      <= pat_d;
      pend_en_q  <= pend_en_d;
      pend_pat_q <= pend_pat_d;
      pending_q  <= pending_d;
      applied_q  <= applied_d;
      sof_err_q  <= sof_err_d;
      line_q     <= line_d;
    end
  end

`ifdef DEMOSAICING_FRAME_STAT_EN
  logic [31:0] frame_q;
  logic        frame_done;

  assign frame_done = (state_q == ACTIVE) && beat && !tuser_i && tlast_i && (line_q == LAST_LINE);

  always_ff @(posedge clk_i) begin
    if (rst_i)           frame_q <= '0;
    else if (frame_done) frame_q <= frame_q + 32'd1;
  end

  assign frame_cnt_o = frame_q;
  assign line_cnt_o  = line_q;
`else
  assign frame_cnt_o = '0;
  assign line_cnt_o  = '0;
`endif

  assign en_o          = en_q;
  assign pattern_o     = pat_q;
  assign cfg_pending_o = pending_q;
  assign cfg_applied_o = applied_q;
  assign sof_err_o     = sof_err_q;
endmodule

// File: tb/tb_demosaicing_frame_ctrl.sv
// Directed/randomized bench for demosaicing_frame_ctrl with a transaction-level framing model.
module tb_demosaicing_frame_ctrl;
  localparam int FL = 4;
  localparam int LW = 16;
`ifdef DEMOSAICING_FRAME_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk_i = 1'b0, rst_i = 1'b0;
  logic en_i = 1'b0, cfg_upd_i = 1'b0;
  logic [1:0] pattern_i = 2'b00;
  logic tvalid_i = 1'b0, tready_i = 1'b0, tuser_i = 1'b0, tlast_i = 1'b0;
  logic hold_o, en_o, cfg_pending_o, cfg_applied_o, sof_err_o;
  logic [1:0] pattern_o;
  logic [31:0] frame_cnt_o;
  logic [LW-1:0] line_cnt_o;

  demosaicing_frame_ctrl #(.FRAME_LINES(FL), .LINE_CNT_W(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pattern_i(pattern_i), .cfg_upd_i(cfg_upd_i),
    .tvalid_i(tvalid_i), .tready_i(tready_i), .tuser_i(tuser_i), .tlast_i(tlast_i),
    .hold_o(hold_o), .en_o(en_o), .pattern_o(pattern_o), .cfg_pending_o(cfg_pending_o),
    .cfg_applied_o(cfg_applied_o), .sof_err_o(sof_err_o), .frame_cnt_o(frame_cnt_o),
    .line_cnt_o(line_cnt_o));

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;
  // Transaction-level model of what the datapath should see
  logic       exp_en, pend_en, exp_pend, exp_err, in_frame;
  logic [1:0] exp_pat, pend_pat;
  int         exp_line, exp_frames;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"}, 32'(en_o), 32'(exp_en));
    chk({tag, ".pat"}, 32'(pattern_o), 32'(exp_pat));
    chk({tag, ".pend"}, 32'(cfg_pending_o), 32'(exp_pend));
    chk({tag, ".err"}, 32'(sof_err_o), 32'(exp_err));
    chk({tag, ".line"}, 32'(line_cnt_o), STAT ? 32'(exp_line) : 32'd0);
    chk({tag, ".frames"}, frame_cnt_o, STAT ? 32'(exp_frames) : 32'd0);
  endtask

  task automatic model_reset();
    exp_en = 0; exp_pat = 0; pend_en = 0; pend_pat = 0; exp_pend = 0;
    exp_err = 0; in_frame = 0; exp_line = 0; exp_frames = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1; tick(); tick(); rst_i = 0;
    model_reset();
    check_all(tag);
    chk({tag, ".hold"}, 32'(hold_o), 32'd0);
    chk({tag, ".applied"}, 32'(cfg_applied_o), 32'd0);
  endtask

  // Mid-frame update: must stay pending and never stall the stream
  task automatic upd(input logic e, input logic [1:0] p);
    en_i = e; pattern_i = p; cfg_upd_i = 1; tick(); cfg_upd_i = 0;
    pend_en = e; pend_pat = p; exp_pend = 1;
    chk("upd.hold", 32'(hold_o), 32'd0);
    chk("upd.pend", 32'(cfg_pending_o), 32'd1);
    chk("upd.applied", 32'(cfg_applied_o), 32'd0);
  endtask

  task automatic do_beat(input logic u, input logic l);
    int n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin  // non-accepted cycles carrying junk sideband
      tvalid_i = 1'($urandom);
      tready_i = tvalid_i ? 1'b0 : 1'($urandom);
      tuser_i = 1'($urandom); tlast_i = 1'($urandom);
      tick();
    end
    tvalid_i = 1; tready_i = 1; tuser_i = u; tlast_i = l;
    tick();
    tvalid_i = 0; tready_i = 0; tuser_i = 0; tlast_i = 0;
    if (in_frame) begin
      if (u) begin
        if (exp_line != 0) exp_err = 1;
        exp_line = l ? 1 : 0;
      end else if (l) begin
        if (exp_line == FL - 1) begin in_frame = 0; exp_line = 0; exp_frames++; end
        else exp_line++;
      end
    end else if (u) begin
      in_frame = 1; exp_line = l ? 1 : 0;
    end
    check_all("beat");
    chk("beat.hold", 32'(hold_o), in_frame ? 32'd0 : 32'(exp_pend));
  endtask

  task automatic line(input logic sof, input int npix);
    for (int i = 0; i < npix; i++) do_beat(sof && i == 0, i == npix - 1);
  endtask

  task automatic frame_lines(input int first, input int last);
    for (int l = first; l <= last; l++) line(l == 0, $urandom_range(1, 3));
  endtask

  // Called just after the final EOL edge with an update pending
  task automatic wait_commit(input string tag);
    chk({tag, ".hold1"}, 32'(hold_o), 32'd1);
    chk({tag, ".en_old"}, 32'(en_o), 32'(exp_en));
    chk({tag, ".pat_old"}, 32'(pattern_o), 32'(exp_pat));
    tick();
    chk({tag, ".hold2"}, 32'(hold_o), 32'd1);
    chk({tag, ".early"}, 32'(cfg_applied_o), 32'd0);
    tick();
    exp_en = pend_en; exp_pat = pend_pat; exp_pend = 0;
    chk({tag, ".applied"}, 32'(cfg_applied_o), 32'd1);
    chk({tag, ".hold3"}, 32'(hold_o), 32'd0);
    check_all(tag);
    tick();
    chk({tag, ".single"}, 32'(cfg_applied_o), 32'd0);
  endtask

  initial begin
    logic       e;
    logic [1:0] p, p2;
    model_reset();
    do_reset("reset");

    // Idle update: pending at N+1, applied at N+2
    en_i = 1; pattern_i = 2; cfg_upd_i = 1; tick(); cfg_upd_i = 0;
    chk("idle.pend", 32'(cfg_pending_o), 32'd1);
    chk("idle.hold", 32'(hold_o), 32'd1);
    chk("idle.en_old", 32'(en_o), 32'd0);
    tick();
    chk("idle.applied", 32'(cfg_applied_o), 32'd1);
    chk("idle.en", 32'(en_o), 32'd1);
    chk("idle.pat", 32'(pattern_o), 32'd2);
    chk("idle.pend0", 32'(cfg_pending_o), 32'd0);
    exp_en = 1; exp_pat = 2;
    tick();
    chk("idle.pulse", 32'(cfg_applied_o), 32'd0);

    for (int k = 0; k < 4; k++) begin
      e = 1'($urandom); p = 2'($urandom);
      en_i = e; pattern_i = p; cfg_upd_i = 1; tick(); cfg_upd_i = 0; tick();
      exp_en = e; exp_pat = p;
      chk("ridle.applied", 32'(cfg_applied_o), 32'd1);
      check_all("ridle");
      tick();
    end

    // Update landing in the COMMIT cycle gets a second commit
    p = 2'($urandom); p2 = ~p;
    en_i = 0; pattern_i = p; cfg_upd_i = 1; tick();
    en_i = 1; pattern_i = p2; tick(); cfg_upd_i = 0;
    chk("b2b.applied1", 32'(cfg_applied_o), 32'd1);
    chk("b2b.pat1", 32'(pattern_o), 32'(p));
    chk("b2b.pend", 32'(cfg_pending_o), 32'd1);
    chk("b2b.hold", 32'(hold_o), 32'd1);
    tick();
    chk("b2b.gap", 32'(cfg_applied_o), 32'd0);
    tick();
    chk("b2b.applied2", 32'(cfg_applied_o), 32'd1);
    chk("b2b.pat2", 32'(pattern_o), 32'(p2));
    chk("b2b.en2", 32'(en_o), 32'd1);
    exp_en = 1; exp_pat = p2;
    tick();

    // Update during line 1 commits only after the 4th EOL
    frame_lines(0, 0);
    line(0, 1);
    upd(1'($urandom), 2'($urandom));
    frame_lines(2, FL - 1);
    wait_commit("fend");
    frame_lines(0, 0);
    upd(1'($urandom), 2'($urandom));  // hold stays low: SOF was accepted into ACTIVE
    frame_lines(1, FL - 1);
    wait_commit("fend2");

    // Last write wins across three mid-frame updates
    frame_lines(0, 1);
    upd(1'($urandom), 2'd1);
    upd(1'($urandom), 2'd3);
    upd(1'($urandom), 2'd0);
    frame_lines(2, FL - 1);
    wait_commit("multi");

    // Early SOF at line 2 restarts the frame without a commit
    frame_lines(0, 1);
    do_beat(1, 0);
    chk("esof.err", 32'(sof_err_o), 32'd1);
    upd(1'($urandom), 2'($urandom));
    do_beat(0, 1);
    frame_lines(1, FL - 1);
    wait_commit("esof");
    chk("esof.sticky", 32'(sof_err_o), 32'd1);

    // Five clean frames, then reset in the middle of the sixth
    do_reset("reset2");
    for (int f = 0; f < 5; f++) frame_lines(0, FL - 1);
    chk("stat.frames5", frame_cnt_o, STAT ? 32'd5 : 32'd0);
    frame_lines(0, 1);
    upd(1, 3);
    do_beat(1, 0);
    do_reset("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
